// File: rtl/panda_lsu.sv
`default_nettype none
// ============================================================================
// Module     : panda_lsu
// Description: Load/store unit for the Panda RV32I execute stage. Issues one
//              access at a time on a req/gnt/rvalid data port, builds byte
//              enables and lane-replicated store data, and returns
//              sign/zero-extended load data. busy_o stalls the pipeline.
// Revision   : 1.0 - initial release
// ============================================================================
module panda_lsu #(
    parameter int ADDR_WIDTH  = 32,
    parameter bit ALIGN_CHECK = 1'b1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_i,
    input  logic                  we_i,
    input  logic [1:0]            width_i,
    input  logic                  unsigned_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [31:0]           wdata_i,
    output logic [31:0]           rdata_o,
    output logic                  valid_o,
    output logic                  busy_o,
    output logic                  err_misaligned_o,
    output logic                  data_req_o,
    input  logic                  data_gnt_i,
    input  logic                  data_rvalid_i,
    output logic                  data_we_o,
    output logic [3:0]            data_be_o,
    output logic [ADDR_WIDTH-1:0] data_addr_o,
    output logic [31:0]           data_wdata_o,
    input  logic [31:0]           data_rdata_i
);

    // lsu_width_e encoding; 2'b11 falls into the WORD branches via default
    localparam logic [1:0] WIDTH_BYTE = 2'b00;
    localparam logic [1:0] WIDTH_HALF = 2'b01;

    typedef enum logic [1:0] {
        S_IDLE        = 2'd0,
        S_WAIT_GNT    = 2'd1,
        S_WAIT_RVALID = 2'd2
    } state_e;

    state_e                  state_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [3:0]              be_q;
    logic                    we_q;
    logic [31:0]             wdata_q;
    logic [1:0]              width_q;
    logic                    unsigned_q;
    logic [1:0]              off_q;

    logic [1:0]              off_d;
    logic [3:0]              be_d;
    logic [31:0]             wdata_d;
    logic [ADDR_WIDTH-1:0]   addr_d;
    logic                    misaligned;
    logic                    accept;
    logic                    complete;
    logic [31:0]             load_shifted;
    logic [31:0]             load_ext;

    assign off_d  = addr_i[1:0];
    assign addr_d = {addr_i[ADDR_WIDTH-1:2], 2'b00};

    // Request decode: byte enables, replicated store data, alignment check
    always_comb begin
        be_d       = 4'b1111;
        wdata_d    = wdata_i;
        misaligned = 1'b0;
        case (width_i)
            WIDTH_BYTE: begin
                be_d    = 4'b0001 << off_d;
                wdata_d = {4{wdata_i[7:0]}};
            end
            WIDTH_HALF: begin
                be_d       = 4'b0011 << off_d;
                wdata_d    = {2{wdata_i[15:0]}};
                misaligned = off_d[0];
            end
            default: begin
                be_d       = 4'b1111;
                wdata_d    = wdata_i;
                misaligned = |off_d;
            end
        endcase
        if (!ALIGN_CHECK) begin
            misaligned = 1'b0;
        end
    end

    // Outputs are gated by rst_i so a reset cycle shows reset values immediately
    assign accept   = !rst_i && (state_q == S_IDLE) && req_i && !misaligned;
    assign complete = !rst_i && (state_q == S_WAIT_RVALID) && data_rvalid_i;

    // Access FSM plus the request registers that hold the bus stable until grant
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            be_q       <= 4'b0000;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            width_q    <= 2'b00;
            unsigned_q <= 1'b0;
            off_q      <= 2'b00;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        addr_q     <= addr_d;
                        be_q       <= be_d;
                        we_q       <= we_i;
                        wdata_q    <= wdata_d;
                        width_q    <= width_i;
                        unsigned_q <= unsigned_i;
                        off_q      <= off_d;
                        state_q    <= S_WAIT_GNT;
                    end
                end
                S_WAIT_GNT: begin
                    if (data_gnt_i) begin
                        state_q <= S_WAIT_RVALID;
                    end
                end
                S_WAIT_RVALID: begin
                    if (data_rvalid_i) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Load alignment and extension from the captured offset/width/sign mode
    always_comb begin
        load_shifted = data_rdata_i >> {off_q, 3'b000};
        case (width_q)
            WIDTH_BYTE: load_ext = unsigned_q ? {24'h000000, load_shifted[7:0]}
                                              : {{24{load_shifted[7]}}, load_shifted[7:0]};
            WIDTH_HALF: load_ext = unsigned_q ? {16'h0000, load_shifted[15:0]}
                                              : {{16{load_shifted[15]}}, load_shifted[15:0]};
            default:    load_ext = load_shifted;
        endcase
    end

    assign valid_o          = complete;
    assign rdata_o          = (complete && !we_q) ? load_ext : 32'h0000_0000;
    assign err_misaligned_o = !rst_i && (state_q == S_IDLE) && req_i && misaligned;
    assign data_req_o       = !rst_i && (state_q == S_WAIT_GNT);
    assign busy_o           = accept
                              || (!rst_i && (state_q == S_WAIT_GNT))
                              || (!rst_i && (state_q == S_WAIT_RVALID) && !data_rvalid_i);
    assign data_we_o        = we_q;
    assign data_be_o        = be_q;
    assign data_addr_o      = addr_q;
    assign data_wdata_o     = wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_panda_lsu.sv
`default_nettype none
// ============================================================================
// Module     : tb_panda_lsu
// Description: Directed self-checking bench for panda_lsu (ALIGN_CHECK=1).
// Revision   : 1.0 - initial release
// ============================================================================
module tb_panda_lsu;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_i;
    logic        we_i;
    logic [1:0]  width_i;
    logic        unsigned_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic [31:0] rdata_o;
    logic        valid_o;
    logic        busy_o;
    logic        err_misaligned_o;
    logic        data_req_o;
    logic        data_gnt_i;
    logic        data_rvalid_i;
    logic        data_we_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_addr_o;
    logic [31:0] data_wdata_o;
    logic [31:0] data_rdata_i;

    int n_vec = 0;
    int n_err = 0;

    panda_lsu #(.ADDR_WIDTH(32), .ALIGN_CHECK(1'b1)) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .req_i            (req_i),
        .we_i             (we_i),
        .width_i          (width_i),
        .unsigned_i       (unsigned_i),
        .addr_i           (addr_i),
        .wdata_i          (wdata_i),
        .rdata_o          (rdata_o),
        .valid_o          (valid_o),
        .busy_o           (busy_o),
        .err_misaligned_o (err_misaligned_o),
        .data_req_o       (data_req_o),
        .data_gnt_i       (data_gnt_i),
        .data_rvalid_i    (data_rvalid_i),
        .data_we_o        (data_we_o),
        .data_be_o        (data_be_o),
        .data_addr_o      (data_addr_o),
        .data_wdata_o     (data_wdata_o),
        .data_rdata_i     (data_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Move to just after the next rising edge; inputs change here
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // One complete access: request cycle, gnt_dly extra WAIT_GNT cycles,
    // rv_dly extra WAIT_RVALID cycles, then completion with the given read word
    task automatic access(input string tag, input logic we, input logic [1:0] width,
                          input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] rd, input int gnt_dly, input int rv_dly,
                          input logic [3:0] exp_be, input logic [31:0] exp_addr,
                          input logic [31:0] exp_wdata, input logic [31:0] exp_rdata);
        tick();
        req_i = 1'b1; we_i = we; width_i = width; unsigned_i = uns;
        addr_i = addr; wdata_i = wd;
        #1;
        chk({tag, ".acc_busy"}, {31'd0, busy_o}, 32'd1);
        chk({tag, ".acc_req"}, {31'd0, data_req_o}, 32'd0);
        chk({tag, ".acc_err"}, {31'd0, err_misaligned_o}, 32'd0);
        for (int i = 0; i <= gnt_dly; i++) begin
            tick();
            data_gnt_i = (i == gnt_dly);
            #1;
            chk({tag, ".req"}, {31'd0, data_req_o}, 32'd1);
            chk({tag, ".addr"}, data_addr_o, exp_addr);
            chk({tag, ".be"}, {28'd0, data_be_o}, {28'd0, exp_be});
            chk({tag, ".we"}, {31'd0, data_we_o}, {31'd0, we});
            chk({tag, ".wdata"}, data_wdata_o, exp_wdata);
            chk({tag, ".gbusy"}, {31'd0, busy_o}, 32'd1);
        end
        for (int i = 0; i < rv_dly; i++) begin
            tick();
            data_gnt_i = 1'b0;
            #1;
            chk({tag, ".rwait_busy"}, {31'd0, busy_o}, 32'd1);
            chk({tag, ".rwait_valid"}, {31'd0, valid_o}, 32'd0);
            chk({tag, ".rwait_req"}, {31'd0, data_req_o}, 32'd0);
        end
        tick();
        data_gnt_i = 1'b0; data_rvalid_i = 1'b1; data_rdata_i = rd;
        #1;
        chk({tag, ".valid"}, {31'd0, valid_o}, 32'd1);
        chk({tag, ".rdata"}, rdata_o, exp_rdata);
        chk({tag, ".done_busy"}, {31'd0, busy_o}, 32'd0);
        chk({tag, ".done_req"}, {31'd0, data_req_o}, 32'd0);
        tick();
        data_rvalid_i = 1'b0; req_i = 1'b0;
        #1;
        chk({tag, ".idle_valid"}, {31'd0, valid_o}, 32'd0);
        chk({tag, ".idle_busy"}, {31'd0, busy_o}, 32'd0);
    endtask

    initial begin
        rst_i = 1'b1; req_i = 1'b0; we_i = 1'b0; width_i = 2'b00; unsigned_i = 1'b0;
        addr_i = '0; wdata_i = '0; data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_rdata_i = '0;
        tick();
        tick();
        #1;
        chk("rst.valid", {31'd0, valid_o}, 32'd0);
        chk("rst.busy", {31'd0, busy_o}, 32'd0);
        chk("rst.err", {31'd0, err_misaligned_o}, 32'd0);
        chk("rst.req", {31'd0, data_req_o}, 32'd0);
        chk("rst.we", {31'd0, data_we_o}, 32'd0);
        chk("rst.be", {28'd0, data_be_o}, 32'd0);
        chk("rst.addr", data_addr_o, 32'd0);
        chk("rst.wdata", data_wdata_o, 32'd0);
        chk("rst.rdata", rdata_o, 32'd0);
        rst_i = 1'b0;

        // LW 0x100, minimum latency
        access("lw", 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0,
               4'b1111, 32'h100, 32'h0, 32'hDEADBEEF);
        // LB / LBU at offset 3
        access("lb", 1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 32'h80FFFFFF, 0, 0,
               4'b1000, 32'h100, 32'h0, 32'hFFFFFF80);
        access("lbu", 1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 32'h80FFFFFF, 0, 0,
               4'b1000, 32'h100, 32'h0, 32'h00000080);
        // SH at offset 2: replicated halfword, rdata_o stays 0 for stores
        access("sh", 1'b1, 2'b01, 1'b0, 32'h202, 32'h1234ABCD, 32'h55555555, 0, 0,
               4'b1100, 32'h200, 32'hABCDABCD, 32'h0);
        // SB at offset 1: replicated byte
        access("sb", 1'b1, 2'b00, 1'b0, 32'h301, 32'h000000A5, 32'h0, 0, 0,
               4'b0010, 32'h300, 32'hA5A5A5A5, 32'h0);
        // LH at offset 2 with gnt withheld 5 cycles and one rvalid wait cycle
        access("lh_slow", 1'b0, 2'b01, 1'b0, 32'h006, 32'h0, 32'h80017F00, 5, 1,
               4'b1100, 32'h004, 32'h0, 32'hFFFF8001);
        // LHU at offset 0
        access("lhu", 1'b0, 2'b01, 1'b1, 32'h008, 32'h0, 32'h12348765, 0, 0,
               4'b0011, 32'h008, 32'h0, 32'h00008765);
        // width encoding 2'b11 behaves as WORD
        access("w11", 1'b0, 2'b11, 1'b0, 32'h00C, 32'h0, 32'hCAFEF00D, 0, 0,
               4'b1111, 32'h00C, 32'h0, 32'hCAFEF00D);

        // Misaligned LW: error pulse, no bus request, no stall
        tick();
        req_i = 1'b1; we_i = 1'b0; width_i = 2'b10; unsigned_i = 1'b0; addr_i = 32'h101;
        #1;
        chk("mis_lw.err", {31'd0, err_misaligned_o}, 32'd1);
        chk("mis_lw.busy", {31'd0, busy_o}, 32'd0);
        chk("mis_lw.req", {31'd0, data_req_o}, 32'd0);
        tick();
        req_i = 1'b0;
        #1;
        chk("mis_lw.req_next", {31'd0, data_req_o}, 32'd0);
        chk("mis_lw.err_next", {31'd0, err_misaligned_o}, 32'd0);
        // Misaligned HALF at offset 3
        tick();
        req_i = 1'b1; width_i = 2'b01; addr_i = 32'h203;
        #1;
        chk("mis_lh.err", {31'd0, err_misaligned_o}, 32'd1);
        chk("mis_lh.busy", {31'd0, busy_o}, 32'd0);
        tick();
        req_i = 1'b0;
        #1;
        chk("mis_lh.req_next", {31'd0, data_req_o}, 32'd0);

        // Reset while waiting for rvalid, then a late rvalid is ignored
        tick();
        req_i = 1'b1; we_i = 1'b0; width_i = 2'b10; addr_i = 32'h400;
        tick();
        data_gnt_i = 1'b1;
        tick();
        data_gnt_i = 1'b0;
        #1;
        chk("rmid.busy_pre", {31'd0, busy_o}, 32'd1);
        tick();
        rst_i = 1'b1; req_i = 1'b0;
        #1;
        chk("rmid.busy_rst", {31'd0, busy_o}, 32'd0);
        tick();
        rst_i = 1'b0; data_rvalid_i = 1'b1; data_rdata_i = 32'h11111111;
        #1;
        chk("rmid.valid", {31'd0, valid_o}, 32'd0);
        chk("rmid.rdata", rdata_o, 32'd0);
        chk("rmid.busy", {31'd0, busy_o}, 32'd0);
        chk("rmid.req", {31'd0, data_req_o}, 32'd0);
        chk("rmid.be", {28'd0, data_be_o}, 32'd0);
        chk("rmid.addr", data_addr_o, 32'd0);
        tick();
        data_rvalid_i = 1'b0;
        #1;
        chk("rmid.req_after", {31'd0, data_req_o}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
